// File: rtl/raider_route_decoder.sv
// Snoops host SPI read commands and steers flash MISO through prioritised address windows; optional per-window hit counters under RAIDER_HIT_COUNT_EN.
// Latency: SYNC_STAGES+1 clk from a host pin edge to its event, plus 1 clk from the last address bit to sel_valid/flash_sel.
// Backpressure: none; this is a passive snooper and SCK <= clk/10 keeps every host edge visible.
module raider_route_decoder #(
   parameter  int NUM_RANGES  = 4,
   parameter  int NUM_FLASH   = 2,
   parameter  int ADDR_W      = 24,
   parameter  int SYNC_STAGES = 2,
   parameter  int CNT_W       = 16,
   localparam int SEL_W       = (NUM_FLASH > 1) ? $clog2(NUM_FLASH) : 1,
   localparam int HI_W        = (NUM_RANGES > 1) ? $clog2(NUM_RANGES) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        h_clk,
   input  logic                        h_cs_n,
   input  logic                        h_mosi,
   input  logic [NUM_RANGES*ADDR_W-1:0] range_start,
   input  logic [NUM_RANGES*ADDR_W-1:0] range_end,
   input  logic [NUM_RANGES-1:0]       range_en,
   input  logic [NUM_RANGES*SEL_W-1:0] range_target,
   input  logic [SEL_W-1:0]            default_target,
   output logic [SEL_W-1:0]            flash_sel,
   output logic                        sel_valid,
   output logic                        hit,
   output logic [HI_W-1:0]             hit_index,
   output logic                        addr4_mode,
   output logic [7:0]                  cur_instr,
   output logic [31:0]                 cur_addr,
   output logic [2:0]                  state,
   output logic [NUM_RANGES*CNT_W-1:0] hit_count
);

   // A single-stage synchroniser is not safe, so shallower requests are clamped to 2.
   localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_OPCODE  = 3'd1,
      S_ADDR    = 3'd2,
      S_ROUTED  = 3'd3,
      S_PASS    = 3'd4,
      S_WAIT_CS = 3'd5
   } state_t;

   logic [SYNC_N-1:0] r_sync_sck;
   logic [SYNC_N-1:0] r_sync_cs;
   logic [SYNC_N-1:0] r_sync_mosi;
   logic              r_sck_d;
   logic              r_cs_d;

   logic              w_sck;
   logic              w_cs;
   logic              w_mosi;
   logic              w_sck_rise;
   logic              w_cs_rise;
   logic              w_cs_fall;

   state_t            r_state;
   logic [5:0]        r_bit_cnt;
   logic [31:0]       r_shift;
   logic              r_addr_len4;
   logic              r_resolve;
   logic              r_addr4_mode;
   logic [7:0]        r_cur_instr;
   logic [31:0]       r_cur_addr;
   logic [SEL_W-1:0]  r_flash_sel;
   logic              r_sel_valid;
   logic              r_hit;
   logic [HI_W-1:0]   r_hit_index;

   logic [31:0]       w_shift_nxt;
   logic [5:0]        w_last_bit;
   logic [31:0]       w_addr_full;
   logic [ADDR_W-1:0] w_addr_cmp;
   logic              w_match;
   logic [HI_W-1:0]   w_match_idx;
   logic [SEL_W-1:0]  w_match_tgt;

   // Synchronisers run through reset so WAIT_CS always sees the true CS level.
   always_ff @(posedge clk) begin
      r_sync_sck  <= {r_sync_sck[SYNC_N-2:0], h_clk};
      r_sync_cs   <= {r_sync_cs[SYNC_N-2:0], h_cs_n};
      r_sync_mosi <= {r_sync_mosi[SYNC_N-2:0], h_mosi};
      r_sck_d     <= r_sync_sck[SYNC_N-1];
      r_cs_d      <= r_sync_cs[SYNC_N-1];
   end

   assign w_sck      = r_sync_sck[SYNC_N-1];
   assign w_cs       = r_sync_cs[SYNC_N-1];
   assign w_mosi     = r_sync_mosi[SYNC_N-1];
   assign w_sck_rise = w_sck & ~r_sck_d & ~w_cs;
   assign w_cs_rise  = w_cs & ~r_cs_d;
   assign w_cs_fall  = ~w_cs & r_cs_d;

   // MSB-first shift; after the last address bit the shifter holds the whole address.
   assign w_shift_nxt = {r_shift[30:0], w_mosi};
   assign w_last_bit  = r_addr_len4 ? 6'd39 : 6'd31;
   assign w_addr_full = r_addr_len4 ? r_shift : {8'h00, r_shift[23:0]};
   assign w_addr_cmp  = w_addr_full[ADDR_W-1:0];

   // Window match: scan from the lowest priority upward so the lowest index wins.
   always_comb begin
      w_match     = 1'b0;
      w_match_idx = '0;
      w_match_tgt = default_target;
      for (int i = NUM_RANGES - 1; i >= 0; i--) begin
         if (range_en[i] &&
             (range_start[i*ADDR_W +: ADDR_W] <= w_addr_cmp) &&
             (w_addr_cmp <= range_end[i*ADDR_W +: ADDR_W])) begin
            w_match     = 1'b1;
            w_match_idx = HI_W'(i);
            w_match_tgt = range_target[i*SEL_W +: SEL_W];
         end
      end
   end

   // Decode FSM; CS rise aborts from any state, rst overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_WAIT_CS;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_addr_len4  <= 1'b0;
         r_resolve    <= 1'b0;
         r_addr4_mode <= 1'b0;
         r_cur_instr  <= '0;
         r_cur_addr   <= '0;
         r_flash_sel  <= '0;
         r_sel_valid  <= 1'b0;
         r_hit        <= 1'b0;
         r_hit_index  <= '0;
      end else begin
         r_sel_valid <= 1'b0;
         if (w_cs_rise) begin
            r_state     <= S_IDLE;
            r_flash_sel <= default_target;
            r_resolve   <= 1'b0;
            // EN4B/EX4B only count when the command was exactly one byte long.
            if (r_state == S_PASS && r_bit_cnt == 6'd8) begin
               if (r_shift[7:0] == 8'hB7) begin
                  r_addr4_mode <= 1'b1;
               end else if (r_shift[7:0] == 8'hE9) begin
                  r_addr4_mode <= 1'b0;
               end
            end
         end else begin
            case (r_state)
               S_WAIT_CS: begin
                  if (w_cs) begin
                     r_state <= S_IDLE;
                  end
               end
               S_IDLE: begin
                  if (w_cs_fall) begin
                     r_state     <= S_OPCODE;
                     r_flash_sel <= default_target;
                     r_bit_cnt   <= '0;
                     r_shift     <= '0;
                  end
               end
               S_OPCODE: begin
                  if (w_sck_rise) begin
                     r_shift   <= w_shift_nxt;
                     r_bit_cnt <= r_bit_cnt + 6'd1;
                     if (r_bit_cnt == 6'd7) begin
                        r_cur_instr <= w_shift_nxt[7:0];
                        case (w_shift_nxt[7:0])
                           8'h03, 8'h0B: begin
                              r_state     <= S_ADDR;
                              r_addr_len4 <= r_addr4_mode;
                           end
                           8'h13, 8'h0C: begin
                              r_state     <= S_ADDR;
                              r_addr_len4 <= 1'b1;
                           end
                           default: r_state <= S_PASS;
                        endcase
                     end
                  end
               end
               S_ADDR: begin
                  if (r_resolve) begin
                     r_resolve   <= 1'b0;
                     r_state     <= S_ROUTED;
                     r_cur_addr  <= w_addr_full;
                     r_flash_sel <= w_match ? w_match_tgt : default_target;
                     r_hit       <= w_match;
                     r_hit_index <= w_match ? w_match_idx : '0;
                     r_sel_valid <= 1'b1;
                  end else if (w_sck_rise) begin
                     r_shift   <= w_shift_nxt;
                     r_bit_cnt <= r_bit_cnt + 6'd1;
                     if (r_bit_cnt == w_last_bit) begin
                        r_resolve <= 1'b1;
                     end
                  end
               end
               S_ROUTED: begin
                  r_state <= S_ROUTED;
               end
               S_PASS: begin
                  // Keep counting so an over-long EN4B/EX4B is rejected at CS rise.
                  if (w_sck_rise && r_bit_cnt != 6'h3F) begin
                     r_shift   <= w_shift_nxt;
                     r_bit_cnt <= r_bit_cnt + 6'd1;
                  end
               end
               default: r_state <= S_WAIT_CS;
            endcase
         end
      end
   end

   assign flash_sel  = r_flash_sel;
   assign sel_valid  = r_sel_valid;
   assign hit        = r_hit;
   assign hit_index  = r_hit_index;
   assign addr4_mode = r_addr4_mode;
   assign cur_instr  = r_cur_instr;
   assign cur_addr   = r_cur_addr;
   assign state      = r_state;

`ifdef RAIDER_HIT_COUNT_EN
   logic [CNT_W-1:0] r_hit_cnt [NUM_RANGES];

   // Saturating per-window hit counters, cleared only by rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_RANGES; i++) begin
            r_hit_cnt[i] <= '0;
         end
      end else if (r_sel_valid && r_hit && (r_hit_cnt[r_hit_index] != {CNT_W{1'b1}})) begin
         r_hit_cnt[r_hit_index] <= r_hit_cnt[r_hit_index] + CNT_W'(1);
      end
   end

   for (genvar g = 0; g < NUM_RANGES; g++) begin : g_cnt
      assign hit_count[g*CNT_W +: CNT_W] = r_hit_cnt[g];
   end
`else
   assign hit_count = '0;
`endif

endmodule

// File: tb/tb_raider_route_decoder.sv
`timescale 1ns/1ps
module tb_raider_route_decoder;

   localparam int NR = 4;
   localparam int AW = 32;
   localparam int CW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            h_clk;
   logic            h_cs_n;
   logic            h_mosi;
   logic [NR*AW-1:0] range_start;
   logic [NR*AW-1:0] range_end;
   logic [NR-1:0]   range_en;
   logic [NR-1:0]   range_target;
   logic            default_target;
   logic            flash_sel;
   logic            sel_valid;
   logic            hit;
   logic [1:0]      hit_index;
   logic            addr4_mode;
   logic [7:0]      cur_instr;
   logic [31:0]     cur_addr;
   logic [2:0]      state;
   logic [NR*CW-1:0] hit_count;

   typedef struct {
      logic        hit;
      logic [1:0]  idx;
      logic        sel;
      logic [31:0] addr;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   model_cnt [NR];

   raider_route_decoder #(
      .NUM_RANGES(NR), .NUM_FLASH(2), .ADDR_W(AW), .SYNC_STAGES(2), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .h_clk(h_clk), .h_cs_n(h_cs_n), .h_mosi(h_mosi),
      .range_start(range_start), .range_end(range_end), .range_en(range_en),
      .range_target(range_target), .default_target(default_target),
      .flash_sel(flash_sel), .sel_valid(sel_valid), .hit(hit), .hit_index(hit_index),
      .addr4_mode(addr4_mode), .cur_instr(cur_instr), .cur_addr(cur_addr),
      .state(state), .hit_count(hit_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every sel_valid pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (sel_valid === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sel_valid: got pulse expected none, addr 0x%0h at %0t", cur_addr, $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("route_hit", {31'd0, hit}, {31'd0, e.hit});
            chk("route_index", {30'd0, hit_index}, {30'd0, e.idx});
            chk("route_flash_sel", {31'd0, flash_sel}, {31'd0, e.sel});
            chk("route_cur_addr", cur_addr, e.addr);
         end
      end
   end

   task automatic expect_route(input logic h, input int idx, input logic sel, input logic [31:0] addr);
      exp_t e;
      e.hit = h; e.idx = idx[1:0]; e.sel = sel; e.addr = addr;
      q.push_back(e);
      if (h && model_cnt[idx] < 3) model_cnt[idx]++;
   endtask

   task automatic set_range(input int i, input logic [31:0] s, input logic [31:0] e,
                            input logic en, input logic tgt);
      range_start[i*AW +: AW] = s;
      range_end[i*AW +: AW]   = e;
      range_en[i]             = en;
      range_target[i]         = tgt;
   endtask

   task automatic spi_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         h_mosi = b[i];
         #50 h_clk = 1'b1;
         #50 h_clk = 1'b0;
      end
   endtask

   task automatic cs_low();
      h_cs_n = 1'b0;
      #100;
   endtask

   task automatic cs_high();
      #100 h_cs_n = 1'b1;
      #200;
   endtask

   // Full transaction of n bytes taken MSB-first from d, then drain check.
   task automatic run(input int n, input logic [39:0] d);
      cs_low();
      for (int k = 0; k < n; k++) spi_byte(d[8*(n-1-k) +: 8]);
      cs_high();
      chk("queue_drained", q.size(), 0);
      q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; h_clk = 1'b0; h_cs_n = 1'b1; h_mosi = 1'b0;
      range_start = '0; range_end = '0; range_en = '0; range_target = '0;
      default_target = 1'b0;
      for (int i = 0; i < NR; i++) model_cnt[i] = 0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_state", state, 32'd5);
      chk("rst_flash_sel", flash_sel, 0);
      chk("rst_sel_valid", sel_valid, 0);
      chk("rst_hit", hit, 0);
      chk("rst_addr4", addr4_mode, 0);
      chk("rst_cur_addr", cur_addr, 0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("post_rst_idle", state, 32'd0);

      // Basic 3-byte read into window 0.
      set_range(0, 32'h0010_0000, 32'h001F_FFFF, 1'b1, 1'b1);
      expect_route(1'b1, 0, 1'b1, 32'h0012_3456);
      run(4, 40'h00_0312_3456);
      chk("t1_sel_after_cs", flash_sel, 0);
      chk("t1_state_idle", state, 32'd0);
      chk("t1_instr", cur_instr, 32'h03);

      // Overlapping windows: lowest index wins, then falls to window 1.
      set_range(0, 32'h0, 32'hFF, 1'b1, 1'b1);
      set_range(1, 32'h0, 32'hFFFF, 1'b1, 1'b0);
      expect_route(1'b1, 0, 1'b1, 32'h80);
      run(4, 40'h00_0B00_0080);
      range_en[0] = 1'b0;
      expect_route(1'b1, 1, 1'b0, 32'h80);
      run(4, 40'h00_0B00_0080);
      // Inverted window never matches; no match routes to default.
      set_range(2, 32'h0002_0300, 32'h0002_0200, 1'b1, 1'b1);
      default_target = 1'b1;
      expect_route(1'b0, 0, 1'b1, 32'h0002_0250);
      run(4, 40'h00_0302_0250);
      default_target = 1'b0;
      range_en = '0;

      // 4-byte mode via EN4B, then over-long EX4B ignored, then EX4B.
      run(1, 40'hB7);
      chk("t3_en4b", addr4_mode, 1);
      set_range(0, 32'h0100_0000, 32'h01FF_FFFF, 1'b1, 1'b1);
      expect_route(1'b1, 0, 1'b1, 32'h0112_3456);
      run(5, 40'h03_0112_3456);
      run(2, 40'hE900);
      chk("t3_long_ex4b_ignored", addr4_mode, 1);
      chk("t3_instr_e9", cur_instr, 32'hE9);
      run(1, 40'hE9);
      chk("t3_ex4b", addr4_mode, 0);
      expect_route(1'b1, 0, 1'b1, 32'h0100_0000);
      run(5, 40'h13_0100_0000);
      expect_route(1'b1, 0, 1'b1, 32'h01FF_FFFF);
      run(5, 40'h0C_01FF_FFFF);
      chk("t3_instr_0c", cur_instr, 32'h0C);
      expect_route(1'b0, 0, 1'b0, 32'h0200_0000);
      run(5, 40'h0C_0200_0000);

      // Aborted address and non-read opcode.
      default_target = 1'b1;
      run(2, 40'h0312);
      chk("t4_abort_state", state, 32'd0);
      chk("t4_abort_sel", flash_sel, 1);
      cs_low();
      spi_byte(8'h06);
      #100;
      chk("t4_pass_state", state, 32'd4);
      chk("t4_pass_sel", flash_sel, 1);
      chk("t4_instr", cur_instr, 32'h06);
      cs_high();
      default_target = 1'b0;

      // Reset mid-address with CS held low.
      run(1, 40'hB7);
      chk("t5_pre_addr4", addr4_mode, 1);
      range_en = '0;
      cs_low();
      spi_byte(8'h03);
      spi_byte(8'h12);
      rst = 1'b1;
      for (int i = 0; i < NR; i++) model_cnt[i] = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("t5_rst_state", state, 32'd5);
      chk("t5_rst_hit", hit, 0);
      chk("t5_rst_index", hit_index, 0);
      chk("t5_rst_addr4", addr4_mode, 0);
      chk("t5_rst_instr", cur_instr, 0);
      chk("t5_rst_addr", cur_addr, 0);
      rst = 1'b0;
      spi_byte(8'h34);
      spi_byte(8'h56);
      spi_byte(8'h78);
      #100 chk("t5_wait_cs", state, 32'd5);
      cs_high();
      chk("t5_idle", state, 32'd0);
      expect_route(1'b0, 0, 1'b0, 32'h10);
      run(4, 40'h00_0300_0010);

      // Repeated hits on window 1 for the counters.
      set_range(0, 32'h0, 32'hFF, 1'b1, 1'b1);
      set_range(1, 32'h1000, 32'h1FFF, 1'b1, 1'b0);
      expect_route(1'b1, 1, 1'b0, 32'h1000);
      run(4, 40'h00_0300_1000);
      expect_route(1'b1, 1, 1'b0, 32'h1234);
      run(4, 40'h00_0300_1234);
      expect_route(1'b1, 1, 1'b0, 32'h1FFF);
      run(4, 40'h00_0300_1FFF);
      expect_route(1'b1, 1, 1'b0, 32'h1800);
      run(4, 40'h00_0300_1800);
      for (int i = 0; i < NR; i++) begin
`ifdef RAIDER_HIT_COUNT_EN
         chk($sformatf("hit_count_%0d", i), {30'd0, hit_count[i*CW +: CW]}, model_cnt[i]);
`else
         chk($sformatf("hit_count_%0d", i), {30'd0, hit_count[i*CW +: CW]}, 0);
`endif
      end

      #100;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
